// File: rtl/panda_risc_v_tcm_port_arbiter.sv
// ============================================================================
// panda_risc_v_tcm_port_arbiter
//
// Shares a single TCM/BRAM port between two core-side requesters:
//   M0 : instruction fetch, read-only
//   M1 : load/store, read/write with byte enables
//
// The memory returns read data one cycle after mem_en. Each requester has a
// one-entry response buffer. If a response is not accepted in the cycle it
// appears, it is parked in the buffer, so read data is never lost.
// Arbitration is round-robin between the two requesters.
//
// Optional feature (compile-time macro):
//   TCM_ARB_M1_FIXED_PRIO_EN - when defined, M1 always wins contention and
//                              last_grant is ignored for arbitration.
//                              M0 may starve.
//
// Ports:
//   aclk, areset                 clock, asynchronous active-high reset
//   m0_req_valid/ready/addr      M0 read request channel
//   m0_resp_valid/ready/rdata    M0 response channel
//   m1_req_valid/ready/addr      M1 request channel
//   m1_req_wen/wdata             M1 byte write enables (0 = read) and data
//   m1_resp_valid/ready/rdata    M1 response channel (rdata unused for writes)
//   mem_en/wen/addr/din          memory port command (combinational)
//   mem_dout                     memory read data, valid the cycle after mem_en
// ============================================================================
module panda_risc_v_tcm_port_arbiter #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int SIM_DELAY  = 1
) (
  input  logic                    aclk,
  input  logic                    areset,

  input  logic                    m0_req_valid,
  output logic                    m0_req_ready,
  input  logic [ADDR_WIDTH-1:0]   m0_req_addr,
  output logic                    m0_resp_valid,
  input  logic                    m0_resp_ready,
  output logic [DATA_WIDTH-1:0]   m0_resp_rdata,

  input  logic                    m1_req_valid,
  output logic                    m1_req_ready,
  input  logic [ADDR_WIDTH-1:0]   m1_req_addr,
  input  logic [DATA_WIDTH/8-1:0] m1_req_wen,
  input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
  output logic                    m1_resp_valid,
  input  logic                    m1_resp_ready,
  output logic [DATA_WIDTH-1:0]   m1_resp_rdata,

  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_wen,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // SIM_DELAY is kept for interface compatibility with the rest of the
  // codebase. The register updates here use no delay, so the only reference
  // to it is this empty sanity block.
  if (SIM_DELAY < 0) begin : g_sim_delay_negative
  end

  // --------------------------------------------------------------------------
  // Per-requester state
  // --------------------------------------------------------------------------
  logic                  inflight_0, inflight_1;   // access issued last cycle
  logic                  buf_valid_0, buf_valid_1; // parked response present
  logic [DATA_WIDTH-1:0] buf_data_0, buf_data_1;
  logic                  last_grant;               // 0 = M0 granted last

  logic elig_0, elig_1;
  logic issuable_0, issuable_1;
  logic m1_wins_tie;
  logic grant_0, grant_1;

  // A requester may issue only if it has no unconsumed response left over
  // after this cycle. An inflight response that is consumed this cycle frees
  // the slot, which allows back-to-back issue.
  assign elig_0 = ~buf_valid_0 & ~(inflight_0 & ~m0_resp_ready);
  assign elig_1 = ~buf_valid_1 & ~(inflight_1 & ~m1_resp_ready);

  assign issuable_0 = m0_req_valid & elig_0;
  assign issuable_1 = m1_req_valid & elig_1;

`ifdef TCM_ARB_M1_FIXED_PRIO_EN
  assign m1_wins_tie = 1'b1;
`else
  // Round-robin: M1 wins a tie when M0 was served last.
  assign m1_wins_tie = ~last_grant;
`endif

  // Each ready looks only at the *other* requester's valid, so a ready never
  // depends on its own req_valid. The two readys are mutually exclusive
  // whenever both sides are issuable.
  assign m0_req_ready = ~areset & elig_0 & ~(issuable_1 &  m1_wins_tie);
  assign m1_req_ready = ~areset & elig_1 & ~(issuable_0 & ~m1_wins_tie);

  assign grant_0 = m0_req_valid & m0_req_ready;
  assign grant_1 = m1_req_valid & m1_req_ready;

  // --------------------------------------------------------------------------
  // Memory command: combinational from the current-cycle grant
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    mem_en   = grant_0 | grant_1;
    mem_addr = m0_req_addr;
    mem_wen  = '0;
    mem_din  = m1_req_wdata;   // M0 never writes, so M1's data is always safe
    if (grant_1) begin
      mem_addr = m1_req_addr;
      mem_wen  = m1_req_wen;
    end
  end

  // --------------------------------------------------------------------------
  // Responses: the buffer takes precedence, otherwise bypass mem_dout
  // --------------------------------------------------------------------------
  assign m0_resp_valid = buf_valid_0 | inflight_0;
  assign m1_resp_valid = buf_valid_1 | inflight_1;
  assign m0_resp_rdata = buf_valid_0 ? buf_data_0 : mem_dout;
  assign m1_resp_rdata = buf_valid_1 ? buf_data_1 : mem_dout;

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      inflight_0 <= 1'b0;
      inflight_1 <= 1'b0;
      last_grant <= 1'b1;      // M0 wins the first contention after reset
    end else begin
      inflight_0 <= grant_0;
      inflight_1 <= grant_1;
      if (grant_0) last_grant <= 1'b0;
      if (grant_1) last_grant <= 1'b1;
    end
  end

  // Buffer flags: capture an inflight response that was not accepted, and
  // drain a parked one once it is accepted. Eligibility rules out a capture
  // and a drain in the same cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      buf_valid_0 <= 1'b0;
      buf_valid_1 <= 1'b0;
    end else begin
      if (inflight_0 & ~buf_valid_0 & ~m0_resp_ready) buf_valid_0 <= 1'b1;
      else if (buf_valid_0 & m0_resp_ready)           buf_valid_0 <= 1'b0;

      if (inflight_1 & ~buf_valid_1 & ~m1_resp_ready) buf_valid_1 <= 1'b1;
      else if (buf_valid_1 & m1_resp_ready)           buf_valid_1 <= 1'b0;
    end
  end

  // NOTE: the data buffers are not reset. They are only read while their
  // valid flag is set, and leaving them out of reset keeps them plain
  // enable flops.
  always_ff @(posedge aclk) begin
    if (inflight_0 & ~buf_valid_0 & ~m0_resp_ready) buf_data_0 <= mem_dout;
    if (inflight_1 & ~buf_valid_1 & ~m1_resp_ready) buf_data_1 <= mem_dout;
  end

  // BE_WIDTH documents the byte-enable width relation used by the ports.
  if (BE_WIDTH * 8 != DATA_WIDTH) begin : g_data_width_not_byte_multiple
  end

endmodule
